// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin front end for an 8N1 UART transmitter.
// Bit timing comes from counting oversample ticks from the baud generator.
module uart_tx_scheduler #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            tick_i,
  input  logic            req0_valid_i,
  input  logic [DBIT-1:0] req0_data_i,
  output logic            req0_ready_o,
  input  logic            req1_valid_i,
  input  logic [DBIT-1:0] req1_data_i,
  output logic            req1_ready_o,
  output logic            tx_o,
  output logic            busy_o,
  output logic            grant_o
);
  localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic            ptr;
  logic            sel;

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    sel = req1_valid_i;
    if (req0_valid_i && req1_valid_i) sel = ptr;
  end

  assign req0_ready_o = (state == IDLE) && req0_valid_i && !sel;
  assign req1_ready_o = (state == IDLE) && req1_valid_i &&  sel;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      shreg   <= '0;
      ptr     <= 1'b0;
      grant_o <= 1'b0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready_o || req1_ready_o) begin
            shreg   <= sel ? req1_data_i : req0_data_i;
            grant_o <= sel;
            ptr     <= !sel;
            s       <= '0;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick_i) begin
            if (s == SW'(OS-1)) begin
              s     <= '0;
              n     <= '0;
              tx_o  <= shreg[0];
              state <= DATA;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_i) begin
            if (s == SW'(OS-1)) begin
              s     <= '0;
              shreg <= shreg >> 1;
              // tx is registered, so drive the next bit from shreg[1] now
              if (n == NW'(DBIT-1)) begin
                tx_o  <= 1'b1;
                state <= STOP;
              end else begin
                n    <= n + 1'b1;
                tx_o <= shreg[1];
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick_i) begin
            if (s == SW'(SB_TICK-1)) begin
              s      <= '0;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model compared every
// cycle, plus directed frames with hand-computed line patterns.
module tb_uart_tx_scheduler;
  localparam int OS = 16;
  localparam int SB = 16;

  logic clk, reset_n, tick;
  logic v0, v1, r0, r1, tx, busy, grant;
  logic [7:0] d0, d1;

  int checks = 0;
  int failures = 0;

  uart_tx_scheduler #(.DBIT(8), .OS(OS), .SB_TICK(SB)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .tick_i(tick),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
    .tx_o(tx), .busy_o(busy), .grant_o(grant)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Tick source: periodic every 4 clocks, or random, or stalled.
  bit tick_en = 1, tick_rand = 0;
  int tcnt = 0;
  initial begin
    tick = 0;
    forever begin
      @(posedge clk); #1;
      tcnt = (tcnt + 1) % 4;
      if (!tick_en)      tick = 0;
      else if (tick_rand) tick = ($urandom_range(0, 3) == 0);
      else               tick = (tcnt == 0);
    end
  end

  // Reference model: a frame is a 10-bit vector walked by bit index, each bit
  // lasting a fixed number of ticks.
  logic       m_act, m_ptr, m_grant;
  logic [9:0] m_frame;
  int         m_k, m_t;

  function automatic int blen(int k);
    return (k == 9) ? SB : OS;
  endfunction

  function automatic logic winner(logic a0, logic a1, logic p);
    return (a0 && a1) ? p : a1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 0; m_ptr <= 0; m_grant <= 0; m_k <= 0; m_t <= 0; m_frame <= '1;
    end else if (!m_act) begin
      if (v0 || v1) begin
        m_frame <= {1'b1, winner(v0, v1, m_ptr) ? d1 : d0, 1'b0};
        m_grant <= winner(v0, v1, m_ptr);
        m_ptr   <= !winner(v0, v1, m_ptr);
        m_act   <= 1; m_k <= 0; m_t <= 0;
      end
    end else if (tick) begin
      if (m_t + 1 == blen(m_k)) begin
        m_t <= 0;
        if (m_k == 9) m_act <= 0;
        else          m_k <= m_k + 1;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e, a;
    if (reset_n) begin
      e = {m_act ? m_frame[m_k] : 1'b1, m_act, m_grant,
           !m_act && v0 && !winner(v0, v1, m_ptr),
           !m_act && v1 &&  winner(v0, v1, m_ptr)};
      a = {tx, busy, grant, r0, r1};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t {tx,busy,grant,rdy0,rdy1} act=%b exp=%b", $time, a, e);
      end
    end
  end

  // Monitors: handshake order, ready pulse count, busy run and idle gap lengths.
  int grants[$];
  int gaps[$];
  int r0_cnt = 0, b_run = 0, last_run = 0, i_run = 0;
  always @(negedge clk) begin
    if (v0 && r0) grants.push_back(0);
    if (v1 && r1) grants.push_back(1);
    if (r0) r0_cnt++;
    if (busy) begin
      b_run++;
      if (i_run > 0) begin gaps.push_back(i_run); i_run = 0; end
    end else begin
      i_run++;
      if (b_run > 0) begin last_run = b_run; b_run = 0; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    if (r == 0) begin v0 = 1; d0 = d; end else begin v1 = 1; d1 = d; end
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if ((r == 0 && r0) || (r == 1 && r1)) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    if (r == 0) v0 = 0; else v1 = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!busy && !v0 && !v1) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Samples mid-bit assuming a tick every 4 clocks (64 clocks per bit).
  task automatic capture_frame(output logic [9:0] bits);
    bit ok = 0;
    bits = '1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx === 1'b0) begin ok = 1; break; end
    end
    if (!ok) begin chk("capture_timeout", 0, 1); return; end
    repeat (30) @(negedge clk);
    bits[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (64) @(negedge clk);
      bits[i] = tx;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic wait_busy();
    bit ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    if (!ok) chk("busy_timeout", 0, 1);
  endtask

  task automatic rand_req(input int r, input int cyc);
    bit hs;
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      hs = (r == 0) ? (v0 && r0) : (v1 && r1);
      @(posedge clk); #1;
      if (r == 0) begin
        if (hs || !v0) begin v0 = ($urandom_range(0, 3) == 0); d0 = 8'($urandom); end
        else if ($urandom_range(0, 60) == 0) v0 = 0;
      end else begin
        if (hs || !v1) begin v1 = ($urandom_range(0, 3) == 0); d1 = 8'($urandom); end
        else if ($urandom_range(0, 60) == 0) v1 = 0;
      end
    end
    @(posedge clk); #1;
    if (r == 0) v0 = 0; else v1 = 0;
  endtask

  initial begin
    logic [9:0] bits;
    int gb, pb, rb;
    bit bad;
    logic tx_prev;
    reset_n = 0; v0 = 0; v1 = 0; d0 = 0; d1 = 0;
    repeat (2) @(posedge clk); #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rdy0", r0, 0);
    chk("reset_rdy1", r1, 0);
    chk("reset_grant", grant, 0);
    reset_n = 1;

    // Single byte 0xA5 from req0
    rb = r0_cnt;
    fork
      send(0, 8'hA5);
      capture_frame(bits);
    join
    chk("frame_a5", bits, 10'b1101001010);
    wait_idle();
    chk("rdy0_pulses", r0_cnt - rb, 1);
    chk("busy_len_a5", (last_run >= 637 && last_run <= 640), 1);

    // Contention from a fresh pointer
    do_reset();
    gb = grants.size(); pb = gaps.size();
    fork
      begin send(0, 8'h55); send(0, 8'h55); end
      send(1, 8'h0F);
    join
    wait_idle();
    chk("cont_count", grants.size() - gb, 3);
    if (grants.size() >= gb + 3) begin
      chk("cont_g0", grants[gb], 0);
      chk("cont_g1", grants[gb+1], 1);
      chk("cont_g2", grants[gb+2], 0);
    end
    if (gaps.size() >= pb + 3) begin
      chk("cont_gap1", gaps[pb+1], 1);
      chk("cont_gap2", gaps[pb+2], 1);
    end else chk("cont_gap_count", gaps.size() - pb, 3);
    chk("cont_last_grant", grant, 0);

    // Lone requester 1, two bytes
    gb = grants.size(); pb = gaps.size();
    send(1, 8'hA1);
    send(1, 8'h3E);
    wait_idle();
    chk("lone_count", grants.size() - gb, 2);
    if (grants.size() >= gb + 2) begin
      chk("lone_g0", grants[gb], 1);
      chk("lone_g1", grants[gb+1], 1);
    end
    if (gaps.size() >= pb + 2) chk("lone_gap", gaps[pb+1], 1);
    else chk("lone_gap_count", gaps.size() - pb, 2);

    // Reset during data bit 3 of 0xF0, then a clean 0x81
    fork
      send(0, 8'hF0);
      begin
        wait_busy();
        repeat (286) @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        @(posedge clk); @(posedge clk); #1 reset_n = 1;
      end
    join
    fork
      send(0, 8'h81);
      capture_frame(bits);
    join
    chk("frame_81", bits, 10'b1100000010);
    wait_idle();

    // Tick stall of 200 clocks mid-data
    fork
      send(0, 8'h3C);
      begin
        wait_busy();
        repeat (192) @(negedge clk);
        @(posedge clk); #1; tick_en = 0; tick = 0;
        @(negedge clk);
        tx_prev = tx; bad = 0;
        repeat (199) begin
          @(negedge clk);
          if (tx !== tx_prev || busy !== 1'b1) bad = 1;
        end
        chk("stall_hold", bad, 0);
        @(posedge clk); #1; tick_en = 1;
      end
    join
    wait_idle();
    chk("busy_len_stall", (last_run >= 837 && last_run <= 840), 1);

    // Random traffic with random tick spacing
    tick_rand = 1;
    fork
      rand_req(0, 12000);
      rand_req(1, 12000);
    join
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
